// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   - DEF_DATA_W / DEF_IN_W : default result and operand widths
//   - sh_mode_e             : shift mode encodings carried on mode_i
package barrel_shifter_pipe_pkg;

  localparam int DEF_DATA_W = 44;
  localparam int DEF_IN_W   = 12;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,  // logical shift left, zero fill
    SH_LSR = 2'b01,  // logical shift right, zero fill
    SH_ASR = 2'b10,  // arithmetic shift right, sign fill
    SH_ROL = 2'b11   // rotate left
  } sh_mode_e;

endpackage

// File: rtl/barrel_shifter_pipe_shift_level.sv
// One mux level of the barrel shifter: shifts or rotates by a fixed distance
// DIST when en_i is set, otherwise passes data through unchanged.
// Ports:
//   data_i  : value entering this level
//   mode_i  : shift mode (sh_mode_e encoding)
//   en_i    : shift-amount bit belonging to this level
//   data_o  : value leaving this level
module shift_level
  import barrel_shifter_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIST   = 1
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        mode_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = data_i;
    case (sh_mode_e'(mode_i))
      SH_LSL:  shifted = data_i << DIST;
      SH_LSR:  shifted = data_i >> DIST;
      // Sign bit is preserved by every ASR level, so chaining levels keeps
      // filling with the sign of the extended operand.
      SH_ASR:  shifted = $signed(data_i) >>> DIST;
      SH_ROL:  shifted = (data_i << DIST) | (data_i >> (DATA_W - DIST));
      default: shifted = data_i;
    endcase
  end

  assign data_o = en_i ? shifted : data_i;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter. The operand is extended to DATA_W, then passes
// through LEVELS mux levels (level k shifts by 2^k). A register stage sits
// after every level whose PIPE_MASK bit is set; the last level is always
// registered so data_o is a flop output.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o  : input handshake
//   data_i, signed_i         : operand and its extension mode
//   mode_i, shamt_i          : shift mode and amount
//   out_valid_o / out_ready_i: output handshake
//   data_o                   : result
//
// Handshake: a beat transfers on a rising edge where valid and ready on the
// same side are both high. A valid beat is held stable until it transfers;
// ready may depend combinationally on the downstream ready.
module barrel_shifter_pipe
  import barrel_shifter_pipe_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                IN_W      = DEF_IN_W,
  parameter int                LEVELS    = 6,
  parameter logic [LEVELS-1:0] PIPE_MASK = 6'b100100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [IN_W-1:0]   data_i,
  input  logic              signed_i,
  input  logic [1:0]        mode_i,
  input  logic [LEVELS-1:0] shamt_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o
);

  localparam logic [LEVELS-1:0] MASK_EFF = PIPE_MASK | {1'b1, {(LEVELS-1){1'b0}}};

  // Held low through reset and released by the first clock edge afterwards,
  // so in_ready_o stays low until the block is clocking again.
  logic ready_en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en_q <= 1'b0;
    else       ready_en_q <= 1'b1;
  end

  logic              in_take;
  logic [DATA_W-1:0] ext_data;
  logic [LEVELS-1:0] shamt_adj;

  assign in_take = in_valid_i & ready_en_q;

  if (IN_W < DATA_W) begin : g_ext
    assign ext_data = {{(DATA_W-IN_W){signed_i & data_i[IN_W-1]}}, data_i};
  end else begin : g_noext
    assign ext_data = data_i;
  end

  // A rotate by shamt >= DATA_W is folded into range once here, so the
  // levels only ever see the effective rotate distance.
  always_comb begin
    shamt_adj = shamt_i;
    if (mode_i == SH_ROL && int'(shamt_i) >= DATA_W)
      shamt_adj = shamt_i - LEVELS'(DATA_W);
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    logic              v_in;
    logic              v_out;
    logic              rdy_in;
    logic              rdy_nxt;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_sh;
    logic [DATA_W-1:0] d_out;
    logic [1:0]        m_in;
    // Only the shamt bits still needed by this and later levels travel on.
    logic [LEVELS-1:k] s_in;

    if (k == 0) begin : g_src
      assign v_in = in_take;
      assign d_in = ext_data;
      assign m_in = mode_i;
      assign s_in = shamt_adj;
    end else begin : g_src
      assign v_in = g_lvl[k-1].v_out;
      assign d_in = g_lvl[k-1].d_out;
      assign m_in = g_lvl[k-1].g_fwd.m_out;
      assign s_in = g_lvl[k-1].g_fwd.s_out;
    end

    if (k == LEVELS-1) begin : g_sink
      assign rdy_nxt = out_ready_i;
    end else begin : g_sink
      assign rdy_nxt = g_lvl[k+1].rdy_in;
    end

    shift_level #(
      .DATA_W (DATA_W),
      .DIST   (1 << k)
    ) u_level (
      .data_i (d_in),
      .mode_i (m_in),
      .en_i   (s_in[k]),
      .data_o (d_sh)
    );

    if (MASK_EFF[k]) begin : g_reg
      logic              v_q;
      logic [DATA_W-1:0] d_q;

      // Stage loads whenever it is empty or its content moves on.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else if (rdy_in) begin
          v_q <= v_in;
          if (v_in) d_q <= d_sh;
        end
      end

      assign v_out  = v_q;
      assign d_out  = d_q;
      assign rdy_in = ~v_q | rdy_nxt;
    end else begin : g_comb
      assign v_out  = v_in;
      assign d_out  = d_sh;
      assign rdy_in = rdy_nxt;
    end

    // Mode and remaining shamt bits move in lock-step with the data.
    if (k < LEVELS-1) begin : g_fwd
      logic [1:0]          m_out;
      logic [LEVELS-1:k+1] s_out;

      if (MASK_EFF[k]) begin : g_creg
        logic [1:0]          m_q;
        logic [LEVELS-1:k+1] s_q;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            m_q <= '0;
            s_q <= '0;
          end else if (rdy_in && v_in) begin
            m_q <= m_in;
            s_q <= s_in[LEVELS-1:k+1];
          end
        end

        assign m_out = m_q;
        assign s_out = s_q;
      end else begin : g_ccomb
        assign m_out = m_in;
        assign s_out = s_in[LEVELS-1:k+1];
      end
    end
  end

  assign in_ready_o  = ready_en_q & g_lvl[0].rdy_in;
  assign out_valid_o = g_lvl[LEVELS-1].v_out;
  assign data_o      = g_lvl[LEVELS-1].d_out;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
module tb_barrel_shifter_pipe;

  localparam int DATA_W = 44;
  localparam int IN_W   = 12;
  localparam int LEVELS = 6;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROL = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [IN_W-1:0]   data_i;
  logic              signed_i;
  logic [1:0]        mode_i;
  logic [LEVELS-1:0] shamt_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] data_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  barrel_shifter_pipe #(
    .DATA_W    (DATA_W),
    .IN_W      (IN_W),
    .LEVELS    (LEVELS),
    .PIPE_MASK (6'b100100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .signed_i    (signed_i),
    .mode_i      (mode_i),
    .shamt_i     (shamt_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              held_v = 1'b0;
  logic [DATA_W-1:0] held_d = '0;
  bit                rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: extend, then apply the shift rule with plain operators.
  function automatic logic [DATA_W-1:0] model(input logic [IN_W-1:0] d, input logic s,
                                              input logic [1:0] m, input logic [LEVELS-1:0] sh);
    logic [DATA_W-1:0] x;
    int n;
    x = {32'h0, d};
    if (s && d[IN_W-1]) x = x | 44'hFFF_FFFF_F000;
    n = int'(sh);
    case (m)
      M_LSL:   model = (n >= DATA_W) ? '0 : x << n;
      M_LSR:   model = (n >= DATA_W) ? '0 : x >> n;
      M_ASR:   model = (n >= DATA_W) ? {DATA_W{x[DATA_W-1]}} : DATA_W'($signed(x) >>> n);
      default: begin
        n = n % DATA_W;
        model = (n == 0) ? x : ((x << n) | (x >> (DATA_W - n)));
      end
    endcase
  endfunction

  // ---------------- output ready driver ----------------
  always @(posedge clk) begin
    #2;
    out_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_hold_valid", 64'(out_valid_o), 64'(1'b1));
        check("stall_hold_data", 64'(data_o), 64'(held_d));
      end
      held_v = 1'b0;
      if (out_valid_o) begin
        if (out_ready_i) begin
          n_out++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: got %0h expected no result", data_o);
          end else begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            if (data_o !== e) begin
              failures++;
              $display("FAIL model_data: got %0h expected %0h", data_o, e);
            end
          end
        end else begin
          held_v = 1'b1;
          held_d = data_o;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input logic [IN_W-1:0] d, input logic s, input logic [1:0] m,
                      input logic [LEVELS-1:0] sh);
    int waited = 0;
    in_valid_i = 1'b1;
    data_i     = d;
    signed_i   = s;
    mode_i     = m;
    shamt_i    = sh;
    forever begin
      @(negedge clk);
      if (in_ready_o) break;
      waited++;
      if (waited > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready_o stayed 0 required 1");
        in_valid_i = 1'b0;
        return;
      end
      @(posedge clk); #2;
    end
    exp_q.push_back(model(d, s, m, sh));
    @(posedge clk); #2;
    in_valid_i = 1'b0;
  endtask

  task automatic directed(input string name, input logic [IN_W-1:0] d, input logic s,
                          input logic [1:0] m, input logic [LEVELS-1:0] sh,
                          input logic [DATA_W-1:0] lit);
    int lat;
    send(d, s, m, sh);
    lat = 1;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(2));
    check({name, "_data"}, 64'(data_o), 64'(lit));
    @(posedge clk); #2;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    reset       = 1'b1;
    in_valid_i  = 1'b0;
    data_i      = '0;
    signed_i    = 1'b0;
    mode_i      = '0;
    shamt_i     = '0;
    out_ready_i = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid_o), 64'(1'b0));
    check("reset_data", 64'(data_o), 64'(0));
    check("reset_in_ready", 64'(in_ready_o), 64'(1'b0));
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_before_edge", 64'(in_ready_o), 64'(1'b0));
    @(posedge clk); #2;
    check("in_ready_after_edge", 64'(in_ready_o), 64'(1'b1));

    directed("asr_fff_5",   12'hFFF, 1'b1, M_ASR, 6'd5,  44'hFFF_FFFF_FFFF);
    directed("lsl_1_43",    12'h001, 1'b0, M_LSL, 6'd43, 44'h800_0000_0000);
    directed("lsl_1_44",    12'h001, 1'b0, M_LSL, 6'd44, 44'h000_0000_0000);
    directed("rol_1_45",    12'h001, 1'b0, M_ROL, 6'd45, 44'h000_0000_0002);
    directed("rol_1_43",    12'h001, 1'b0, M_ROL, 6'd43, 44'h800_0000_0000);
    directed("lsr_s800_4",  12'h800, 1'b1, M_LSR, 6'd4,  44'h0FF_FFFF_FF80);
    directed("asr_s800_63", 12'h800, 1'b1, M_ASR, 6'd63, 44'hFFF_FFFF_FFFF);
    directed("rol_abc_0",   12'hABC, 1'b0, M_ROL, 6'd0,  44'h000_0000_0ABC);
    directed("lsl_sabc_8",  12'hABC, 1'b1, M_LSL, 6'd8,  44'hFFF_FFFA_BC00);
    directed("rol_abc_40",  12'hABC, 1'b0, M_ROL, 6'd40, 44'hC00_0000_00AB);
    directed("asr_7ff_50",  12'h7FF, 1'b1, M_ASR, 6'd50, 44'h000_0000_0000);

    // Random stream with random downstream stalls.
    n0 = n_out;
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [IN_W-1:0]   d;
      logic              s;
      logic [1:0]        m;
      logic [LEVELS-1:0] sh;
      d  = IN_W'($urandom_range(0, 4095));
      s  = 1'($urandom_range(0, 1));
      m  = 2'($urandom_range(0, 3));
      sh = LEVELS'($urandom_range(0, 63));
      send(d, s, m, sh);
    end
    for (int c = 0; c < 1000 && exp_q.size() != 0; c++) begin
      @(posedge clk); #2;
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    check("stream_drained", 64'(exp_q.size()), 64'(0));
    check("stream_count", 64'(n_out - n0), 64'(100));

    // Reset with two operands in flight.
    send(12'h123, 1'b0, M_LSL, 6'd1);
    send(12'h456, 1'b0, M_LSR, 6'd2);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("inflight_reset_out_valid", 64'(out_valid_o), 64'(1'b0));
    check("inflight_reset_data", 64'(data_o), 64'(0));
    check("inflight_reset_in_ready", 64'(in_ready_o), 64'(1'b0));
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("rerelease_in_ready_low", 64'(in_ready_o), 64'(1'b0));
    @(posedge clk); #2;
    check("rerelease_in_ready_high", 64'(in_ready_o), 64'(1'b1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_valid", 64'(out_valid_o), 64'(1'b0));
    end

    // Pipeline still works after the mid-flight reset.
    @(posedge clk); #2;
    directed("post_reset_lsr", 12'hF00, 1'b0, M_LSR, 6'd8, 44'h000_0000_000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 44: result width.
REQ-002 SHALL provide parameter IN_W, default 12: input operand width; IN_W <= DATA_W.
REQ-003 SHALL provide parameter LEVELS, default 6: number of mux levels, equal to clog2(DATA_W); also the shift-amount width.
REQ-004 SHALL provide parameter PIPE_MASK, default 6'b100100: bit k set places a register after level k; bit LEVELS-1 is forced to 1.
REQ-005 SHALL provide port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL provide port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL provide port in_valid_i, input, 1: operand valid.
REQ-008 SHALL provide port in_ready_o, output, 1: block accepts the operand this cycle.
REQ-009 SHALL provide port data_i, input, IN_W: operand.
REQ-010 SHALL provide port signed_i, input, 1: sign-extend data_i to DATA_W when 1, zero-extend when 0.
REQ-011 SHALL provide port mode_i, input, 2: 00 LSL zero-fill, 01 LSR zero-fill, 10 ASR sign-fill, 11 ROL rotate left.
REQ-012 SHALL provide port shamt_i, input, LEVELS: shift amount, 0..2^LEVELS-1.
REQ-013 SHALL provide port out_valid_o, output, 1: result valid.
REQ-014 SHALL provide port out_ready_i, input, 1: downstream accepts the result.
REQ-015 SHALL provide port data_o, output, DATA_W: result.

Function
REQ-016 Transfer SHALL occur on a rising edge with valid&ready on the same side; no other edge transfers data.
REQ-017 Level k SHALL shift by 2^k when shamt bit k is 1, and pass through otherwise.
REQ-018 Fill SHALL be: LSL/LSR zero; ASR the sign bit of the extended operand; ROL the bits wrapped from the opposite end.
REQ-019 Shift amount and mode SHALL travel with the data through each register stage (no mixing of stage-0 control with later-stage data).
REQ-020 LSL/LSR with shamt >= DATA_W SHALL yield all zeros; ASR with shamt >= DATA_W SHALL yield all sign bits.
REQ-021 ROL with shamt >= DATA_W SHALL rotate by shamt-DATA_W, computed once at input.
REQ-022 Latency SHALL be popcount(PIPE_MASK) cycles from input transfer to out_valid_o with out_ready_i held high.
REQ-023 Throughput SHALL be one result per cycle with no bubbles while out_ready_i is high.
REQ-024 Each register stage SHALL hold a valid bit and advance when it is empty or the next stage advances.
REQ-025 in_ready_o SHALL equal (first stage empty) OR (first stage advancing), combinationally.
REQ-026 With out_ready_i low, data_o and out_valid_o SHALL hold stable until transfer.
REQ-027 Results SHALL leave in input order; none dropped or duplicated under any out_ready_i pattern.
REQ-028 An input transfer and an output transfer in the same cycle SHALL both complete.

Reset
REQ-029 Reset SHALL asynchronously clear all stage valid bits, data, mode and shamt registers to 0.
REQ-030 During reset: out_valid_o=0, data_o=0, in_ready_o=0.
REQ-031 in_ready_o SHALL rise on the first clk edge after reset deasserts.
REQ-032 Operands in flight when reset asserts SHALL be discarded, with no output afterward.

Structure
REQ-033 A shared package SHALL hold the mode encodings (SH_LSL, SH_LSR, SH_ASR, SH_ROL) and the default DATA_W/IN_W.
REQ-034 One sub-module, shift_level, SHALL implement a single parametrised level (shift distance, mode fill) and be instantiated LEVELS times by generate.

Verification
REQ-035 Verification SHALL check signed_i=1, data_i=12'hFFF, ASR, shamt=5 -> data_o=44'hFFF_FFFF_FFFF after 2 cycles.
REQ-036 Verification SHALL check signed_i=0, data_i=12'h001, LSL, shamt=43 -> 44'h800_0000_0000; then shamt=44 -> 44'h0.
REQ-037 Verification SHALL check data_i=12'h001, ROL, shamt=45 -> 44'h000_0000_0002; shamt=43 -> 44'h800_0000_0000.
REQ-038 Verification SHALL check signed_i=1, data_i=12'h800, LSR, shamt=4 -> 44'h0FF_FFFF_FF80.
REQ-039 Verification SHALL stream 100 random operands with random out_ready_i -> outputs match the model in order, no loss or duplication, data_o stable while stalled.
REQ-040 Verification SHALL assert reset with 2 operands in flight -> out_valid_o=0 immediately, no stale result after release.
